pipeline_hazard_ctrl: RTL
=========================

Name: pipeline_hazard_ctrl

Overview:
- Central sequencer for the 5-stage MIPS pipeline registers (IF/ID, ID/EX, EX/MEM, MEM/WB) and the PC.
- Each cycle it drives per-register write-enable (xW) and synchronous-clear (xRST) strobes. These resolve instruction-memory misses, data-memory waits, load-use hazards, taken branches/jumps and halt drain.
- Keeps saturating stall/flush counters for performance debug.
- Sits beside the datapath in the pipelined CPU top; all pipeline registers take their W/RST from this block only.

Parameters:
- CNT_W, 16, width of stall_cnt and flush_cnt.

Ports:
- CLK  in  1  system clock
- RST  in  1  reset, synchronous, active-high
- ihit  in  1  instruction fetch completed this cycle
- dhit  in  1  data access completed this cycle
- idrs  in  5  rs field of instruction in ID
- idrt  in  5  rt field of instruction in ID
- excuDRE  in  1  instruction in EX is a load
- exrt  in  5  destination reg of instruction in EX
- memcuDRE  in  1  instruction in MEM is a load
- memcuDWE  in  1  instruction in MEM is a store
- memcuHALT  in  1  HALT in MEM
- wbcuHALT  in  1  HALT in WB
- ex_redirect  in  1  taken branch or jump resolved in EX
- pcW  out  1  PC write enable
- ifidW, idexW, exmemW, memwbW  out  1 each  register write enables
- ifidRST, idexRST, exmemRST, memwbRST  out  1 each  register synchronous clears (override W)
- halt  out  1  CPU halted
- stall_cnt  out  CNT_W  cycles in which pcW=0 and state != HALTED
- flush_cnt  out  CNT_W  cycles in which ex_redirect caused a flush

Behaviour:
- States are RUN, DWAIT, DRAIN and HALTED. Decode and outputs are combinational from state and inputs. State and counters are registered.
- RST=1 at a CLK edge forces:
  - state to RUN;
  - stall_cnt and flush_cnt to 0.
- While RST=1, outputs are:
  - all W=0;
  - all xRST=1;
  - pcW=0 and halt=0.
- The memory request is dreq = memcuDRE|memcuDWE.
- A load-use hazard exists when luh = excuDRE & (exrt!=0) & (exrt==idrs | exrt==idrt).
- Default in RUN is all W=1, all xRST=0, pcW=1. The following rules modify it, highest priority first:
  1. dreq & !dhit: pcW=0 and all W=0 (full freeze). Next state is DWAIT.
  2. ex_redirect: pcW=1, ifidRST=1, idexRST=1, exmemW=1, memwbW=1. flush_cnt increments. This applies even if ihit=0; the PC still loads the target.
  3. luh: pcW=0, ifidW=0, idexRST=1 (bubble); EX/MEM and MEM/WB advance.
  4. !ihit: pcW=0 and ifidRST=1 (bubble into ID); the rest advance.
- memcuHALT in RUN with no freeze: pcW=0 and ifidRST=1, idexRST=1, exmemRST=1. MEM/WB advances. Next state is DRAIN. Redirect and luh are ignored that cycle.
- DWAIT:
  - While dhit=0, the full freeze holds.
  - On dhit=1, the RUN rules 2-4 apply that same cycle, and the next state is RUN. If memcuHALT=1 instead, the next state is DRAIN.
  - ex_redirect held during DWAIT is not lost. The datapath holds it because EX is frozen.
- DRAIN:
  - pcW=0; ifid, idex and exmem are held cleared; memwbW=1.
  - When wbcuHALT=1, the next state is HALTED.
- HALTED:
  - halt=1, pcW=0, all W=0, all xRST=0 (state frozen for inspection).
  - Only RST exits.
- stall_cnt increments by 1 in any non-RST cycle with pcW=0 and state!=HALTED. It saturates at all-ones and never wraps. flush_cnt saturates the same way.
- Simultaneous dreq&!dhit and ex_redirect: the freeze wins and the flush occurs on the release cycle. flush_cnt counts once.
- RST asserted in any state, including mid-DWAIT or DRAIN, takes effect at the next edge with no drain.
- Latency: all strobes are combinational and take effect at the same CLK edge. No strobe is delayed by this block.

Test Plan:
- Reset with RST=1 for 2 cycles, then ihit=1 and no hazards → cycle 0 after reset: all W=1, pcW=1, xRST=0, counters 0.
- excuDRE=1, exrt=5, idrs=5 → pcW=0, ifidW=0, idexRST=1, exmemW=memwbW=1, stall_cnt=1. Repeat with exrt=0 → no stall.
- memcuDRE=1 with dhit=0 for 3 cycles, then dhit=1 → all W=0 for 3 cycles in DWAIT, back to RUN with W=1 on the 4th cycle, stall_cnt=3.
- ex_redirect=1 together with ihit=0 → pcW=1, ifidRST=idexRST=1, flush_cnt=1. Same stimulus during dhit=0 → frozen; the flush happens on the dhit=1 cycle.
- memcuHALT=1, then wbcuHALT=1 two cycles later → DRAIN then HALTED. halt=1 and all W=0 persist for 10 cycles. RST=1 returns to RUN with halt=0.
- CNT_W=4 with 20 consecutive load-use stalls → stall_cnt saturates at 15 and never wraps.

Source files
------------

// File: rtl/pipeline_hazard_ctrl_if.sv
// Hazard-control bundle between the pipelined datapath (master) and the
// pipeline sequencer (slave): hazard status in, register strobes and counters out.
interface pipeline_hazard_ctrl_if #(
  parameter int CNT_W = 16
);
  logic             ihit;
  logic             dhit;
  logic [4:0]       idrs;
  logic [4:0]       idrt;
  logic             excuDRE;
  logic [4:0]       exrt;
  logic             memcuDRE;
  logic             memcuDWE;
  logic             memcuHALT;
  logic             wbcuHALT;
  logic             ex_redirect;

  logic             pcW;
  logic             ifidW;
  logic             idexW;
  logic             exmemW;
  logic             memwbW;
  logic             ifidRST;
  logic             idexRST;
  logic             exmemRST;
  logic             memwbRST;
  logic             halt;
  logic [CNT_W-1:0] stall_cnt;
  logic [CNT_W-1:0] flush_cnt;

  modport master (
    output ihit, dhit, idrs, idrt, excuDRE, exrt, memcuDRE, memcuDWE,
           memcuHALT, wbcuHALT, ex_redirect,
    input  pcW, ifidW, idexW, exmemW, memwbW,
           ifidRST, idexRST, exmemRST, memwbRST, halt, stall_cnt, flush_cnt
  );

  modport slave (
    input  ihit, dhit, idrs, idrt, excuDRE, exrt, memcuDRE, memcuDWE,
           memcuHALT, wbcuHALT, ex_redirect,
    output pcW, ifidW, idexW, exmemW, memwbW,
           ifidRST, idexRST, exmemRST, memwbRST, halt, stall_cnt, flush_cnt
  );
endinterface

// File: rtl/pipeline_hazard_ctrl.sv
// Pipeline sequencer: combinational PC/pipeline-register write and clear strobes
// resolving memory waits, load-use, redirects and halt drain, plus debug counters.
module pipeline_hazard_ctrl #(
  parameter int CNT_W = 16
) (
  input  logic                  CLK,
  input  logic                  RST,
  pipeline_hazard_ctrl_if.slave hz
);

  typedef enum logic [1:0] {RUN, DWAIT, DRAIN, HALTED} state_t;

  state_t           state;
  state_t           state_nxt;
  logic [CNT_W-1:0] stall_cnt;
  logic [CNT_W-1:0] flush_cnt;

  logic dreq;
  logic luh;
  logic freeze;
  logic flush_en;
  logic stall_en;

  logic pcW, ifidW, idexW, exmemW, memwbW;
  logic ifidRST, idexRST, exmemRST, memwbRST;
  logic halt;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + {{(CNT_W-1){1'b0}}, 1'b1};
  endfunction

  assign dreq = hz.memcuDRE | hz.memcuDWE;
  assign luh  = hz.excuDRE & (hz.exrt != 5'd0) &
                ((hz.exrt == hz.idrs) | (hz.exrt == hz.idrt));

  // In DWAIT the access is known outstanding, so only dhit releases the freeze.
  assign freeze = ((state == RUN) & dreq & ~hz.dhit) | ((state == DWAIT) & ~hz.dhit);

  always_comb begin
    state_nxt = state;
    pcW       = 1'b1;
    ifidW     = 1'b1;
    idexW     = 1'b1;
    exmemW    = 1'b1;
    memwbW    = 1'b1;
    ifidRST   = 1'b0;
    idexRST   = 1'b0;
    exmemRST  = 1'b0;
    memwbRST  = 1'b0;
    halt      = 1'b0;
    flush_en  = 1'b0;
    if (RST) begin
      {pcW, ifidW, idexW, exmemW, memwbW} = 5'b0;
      {ifidRST, idexRST, exmemRST, memwbRST} = 4'b1111;
    end else begin
      case (state)
        RUN, DWAIT: begin
          if (freeze) begin
            {pcW, ifidW, idexW, exmemW, memwbW} = 5'b0;
            state_nxt = DWAIT;
          end else if (hz.memcuHALT) begin
            // Squash everything younger than the HALT and let it retire.
            pcW       = 1'b0;
            ifidRST   = 1'b1;
            idexRST   = 1'b1;
            exmemRST  = 1'b1;
            state_nxt = DRAIN;
          end else begin
            state_nxt = RUN;
            if (hz.ex_redirect) begin
              ifidRST  = 1'b1;
              idexRST  = 1'b1;
              flush_en = 1'b1;
            end else if (luh) begin
              pcW     = 1'b0;
              ifidW   = 1'b0;
              idexRST = 1'b1;
            end else if (!hz.ihit) begin
              pcW     = 1'b0;
              ifidRST = 1'b1;
            end
          end
        end
        DRAIN: begin
          pcW      = 1'b0;
          ifidW    = 1'b0;
          idexW    = 1'b0;
          exmemW   = 1'b0;
          ifidRST  = 1'b1;
          idexRST  = 1'b1;
          exmemRST = 1'b1;
          if (hz.wbcuHALT) state_nxt = HALTED;
        end
        default: begin
          {pcW, ifidW, idexW, exmemW, memwbW} = 5'b0;
          halt = 1'b1;
        end
      endcase
    end
  end

  assign stall_en = ~RST & ~pcW & (state != HALTED);

  always_ff @(posedge CLK) begin
    if (RST) begin
      state     <= RUN;
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      state <= state_nxt;
      if (stall_en) stall_cnt <= sat_inc(stall_cnt);
      if (flush_en) flush_cnt <= sat_inc(flush_cnt);
    end
  end

  assign hz.pcW       = pcW;
  assign hz.ifidW     = ifidW;
  assign hz.idexW     = idexW;
  assign hz.exmemW    = exmemW;
  assign hz.memwbW    = memwbW;
  assign hz.ifidRST   = ifidRST;
  assign hz.idexRST   = idexRST;
  assign hz.exmemRST  = exmemRST;
  assign hz.memwbRST  = memwbRST;
  assign hz.halt      = halt;
  assign hz.stall_cnt = stall_cnt;
  assign hz.flush_cnt = flush_cnt;

endmodule
